// File: rtl/seq_select_3b_if.sv
// Control and select bundle between a sequencer owner (master) and the
// 3-bit select sequencer (slave). Clock and reset stay outside the bundle.
interface seq_select_3b_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic       mode;
  logic       step_en;
  logic       load;
  logic [2:0] load_val;
  logic       x;
  logic       y;
  logic       z;
  logic       busy;
  logic       done;
  logic       wrap;

  modport master (
    output start, stop, dir, mode, step_en, load, load_val,
    input  x, y, z, busy, done, wrap
  );

  modport slave (
    input  start, stop, dir, mode, step_en, load, load_val,
    output x, y, z, busy, done, wrap
  );
endinterface

// File: rtl/seq_select_3b.sv
// 3-bit select sequencer: steps {x,y,z} up or down once every DIV enabled
// clocks, one-shot or wrapping, for a downstream 3-to-8 decoder.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; load presets the select value
// RUN    | prescaler counting, select stepping on each tick
// DONE   | one-cycle completion pulse after a one-shot terminal tick
module seq_select_3b #(
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_select_3b_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(DIV - 1);

  state_t     state_q;
  logic [3:0] pre_q;
  logic [2:0] sel_q;
  logic       busy_q;
  logic       done_q;
  logic       wrap_q;

  // Terminal value depends on direction: 7 when counting up, 0 when down.
  logic       at_term;
  logic [2:0] sel_step;
  assign at_term  = bus.dir ? (sel_q == 3'd0) : (sel_q == 3'd7);
  assign sel_step = bus.dir ? (sel_q - 3'd1) : (sel_q + 3'd1);

  // Sequencer FSM with prescaler, select register and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= 4'd0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pre_q <= 4'd0;
          if (bus.load) sel_q <= bus.load_val;
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // stop outranks a coincident tick: no step, no pulses
          if (bus.stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pre_q   <= 4'd0;
          end else if (bus.step_en) begin
            if (pre_q == PRE_LAST) begin
              pre_q <= 4'd0;
              if (at_term && !bus.mode) begin
                // one-shot end: select holds at the terminal value
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                sel_q  <= sel_step;
                wrap_q <= at_term;
              end
            end else begin
              pre_q <= pre_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          pre_q   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.x    = sel_q[2];
  assign bus.y    = sel_q[1];
  assign bus.z    = sel_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_select_3b.sv
// Directed bench for seq_select_3b using three instances: DIV=4, DIV=2, DIV=1.
module tb_seq_select_3b;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_select_3b_if ia ();
  seq_select_3b_if ib ();
  seq_select_3b_if ic ();

  seq_select_3b #(.DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  seq_select_3b #(.DIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  seq_select_3b #(.DIV(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd0) begin
      errors++; $display("FAIL reset_sel_a got %0d want 0", {ia.x, ia.y, ia.z});
    end
    checks++;
    if ({ia.busy, ia.done, ia.wrap} !== 3'b000) begin
      errors++; $display("FAIL reset_flags_a got %b want 000", {ia.busy, ia.done, ia.wrap});
    end
    checks++;
    if ({ib.x, ib.y, ib.z, ib.busy, ib.done, ib.wrap} !== 6'd0) begin
      errors++; $display("FAIL reset_b got %b want 000000", {ib.x, ib.y, ib.z, ib.busy, ib.done, ib.wrap});
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_oneshot_up();
    ia.dir = 1'b0; ia.mode = 1'b0; ia.step_en = 1'b1;
    ia.load = 1'b1; ia.load_val = 3'd5;
    cyc(1);
    ia.load = 1'b0;
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd5 || ia.busy !== 1'b0) begin
      errors++; $display("FAIL load_idle sel=%0d busy=%b want sel=5 busy=0", {ia.x, ia.y, ia.z}, ia.busy);
    end
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
    checks++;
    if (ia.busy !== 1'b1 || {ia.x, ia.y, ia.z} !== 3'd5) begin
      errors++; $display("FAIL start_run busy=%b sel=%0d want busy=1 sel=5", ia.busy, {ia.x, ia.y, ia.z});
    end
    cyc(3);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd5) begin
      errors++; $display("FAIL early_tick sel=%0d want 5", {ia.x, ia.y, ia.z});
    end
    cyc(1);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd6) begin
      errors++; $display("FAIL tick1 sel=%0d want 6", {ia.x, ia.y, ia.z});
    end
    // load is ignored while running
    ia.load = 1'b1; ia.load_val = 3'd2;
    cyc(3);
    ia.load = 1'b0;
    cyc(1);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd7) begin
      errors++; $display("FAIL tick2_load_in_run sel=%0d want 7", {ia.x, ia.y, ia.z});
    end
    cyc(3);
    checks++;
    if (ia.done !== 1'b0 || ia.busy !== 1'b1 || {ia.x, ia.y, ia.z} !== 3'd7) begin
      errors++; $display("FAIL pre_done done=%b busy=%b sel=%0d want 0 1 7", ia.done, ia.busy, {ia.x, ia.y, ia.z});
    end
    cyc(1);
    checks++;
    if (ia.done !== 1'b1 || ia.busy !== 1'b0 || ia.wrap !== 1'b0 || {ia.x, ia.y, ia.z} !== 3'd7) begin
      errors++; $display("FAIL done_pulse done=%b busy=%b wrap=%b sel=%0d want 1 0 0 7",
                         ia.done, ia.busy, ia.wrap, {ia.x, ia.y, ia.z});
    end
    // start while in DONE must be ignored
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
    checks++;
    if (ia.done !== 1'b0 || ia.busy !== 1'b0 || {ia.x, ia.y, ia.z} !== 3'd7) begin
      errors++; $display("FAIL done_end done=%b busy=%b sel=%0d want 0 0 7", ia.done, ia.busy, {ia.x, ia.y, ia.z});
    end
    cyc(2);
    checks++;
    if (ia.busy !== 1'b0) begin
      errors++; $display("FAIL start_in_done busy=%b want 0", ia.busy);
    end
  endtask

  task automatic test_wrap_down();
    logic [2:0] exp_seq [3];
    int wraps;
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd7; exp_seq[2] = 3'd6;
    wraps = 0;
    ib.mode = 1'b1; ib.dir = 1'b1; ib.step_en = 1'b1;
    ib.load_val = 3'd1; ib.load = 1'b1; ib.start = 1'b1;
    cyc(1);
    ib.load = 1'b0; ib.start = 1'b0;
    checks++;
    if ({ib.x, ib.y, ib.z} !== 3'd1 || ib.busy !== 1'b1) begin
      errors++; $display("FAIL load_start sel=%0d busy=%b want 1 1", {ib.x, ib.y, ib.z}, ib.busy);
    end
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        cyc(1);
        if (ib.wrap === 1'b1) wraps++;
      end
      checks++;
      if ({ib.x, ib.y, ib.z} !== exp_seq[k] || ib.wrap !== (k == 1)) begin
        errors++; $display("FAIL down_step%0d sel=%0d wrap=%b want %0d %b",
                           k, {ib.x, ib.y, ib.z}, ib.wrap, exp_seq[k], (k == 1));
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL wrap_count got %0d want 1", wraps);
    end
    ib.stop = 1'b1;
    cyc(1);
    ib.stop = 1'b0;
    checks++;
    if (ib.busy !== 1'b0 || {ib.x, ib.y, ib.z} !== 3'd6) begin
      errors++; $display("FAIL stop_b busy=%b sel=%0d want 0 6", ib.busy, {ib.x, ib.y, ib.z});
    end
  endtask

  task automatic test_step_en();
    logic [4:0] pat;
    pat = 5'b11101;  // applied LSB first: 1,0,1,1,1
    ia.dir = 1'b0; ia.mode = 1'b0;
    ia.load = 1'b1; ia.load_val = 3'd0; ia.start = 1'b1;
    cyc(1);
    ia.load = 1'b0; ia.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ia.step_en = pat[i];
      cyc(1);
      checks++;
      if ({ia.x, ia.y, ia.z} !== ((i == 4) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL step_en_cyc%0d sel=%0d want %0d", i + 1, {ia.x, ia.y, ia.z}, (i == 4) ? 1 : 0);
      end
    end
    ia.step_en = 1'b1;
    ia.stop = 1'b1;
    cyc(1);
    ia.stop = 1'b0;
  endtask

  task automatic test_stop_tick();
    ia.load = 1'b1; ia.load_val = 3'd3; ia.start = 1'b1;
    cyc(1);
    ia.load = 1'b0; ia.start = 1'b0;
    cyc(3);
    ia.stop = 1'b1;
    cyc(1);
    ia.stop = 1'b0;
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd3 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.wrap !== 1'b0) begin
      errors++; $display("FAIL stop_vs_tick sel=%0d busy=%b done=%b wrap=%b want 3 0 0 0",
                         {ia.x, ia.y, ia.z}, ia.busy, ia.done, ia.wrap);
    end
    cyc(1);
    checks++;
    if (ia.done !== 1'b0 || ia.busy !== 1'b0) begin
      errors++; $display("FAIL stop_after done=%b busy=%b want 0 0", ia.done, ia.busy);
    end
    // restart: prescaler must have been cleared by stop
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
    cyc(3);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd3) begin
      errors++; $display("FAIL pre_cleared_early sel=%0d want 3", {ia.x, ia.y, ia.z});
    end
    cyc(1);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd4) begin
      errors++; $display("FAIL pre_cleared_tick sel=%0d want 4", {ia.x, ia.y, ia.z});
    end
    cyc(8);
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd6 || ia.busy !== 1'b1) begin
      errors++; $display("FAIL reach6 sel=%0d busy=%b want 6 1", {ia.x, ia.y, ia.z}, ia.busy);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ia.x, ia.y, ia.z} !== 3'd0 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.wrap !== 1'b0) begin
      errors++; $display("FAIL async_rst sel=%0d busy=%b done=%b wrap=%b want 0 0 0 0",
                         {ia.x, ia.y, ia.z}, ia.busy, ia.done, ia.wrap);
    end
    #2;
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || {ia.x, ia.y, ia.z} !== 3'd0) begin
      errors++; $display("FAIL post_rst_idle busy=%b done=%b sel=%0d want 0 0 0",
                         ia.busy, ia.done, {ia.x, ia.y, ia.z});
    end
  endtask

  task automatic test_div1();
    ic.mode = 1'b1; ic.dir = 1'b0; ic.step_en = 1'b1;
    ic.load_val = 3'd6; ic.load = 1'b1; ic.start = 1'b1;
    cyc(1);
    ic.load = 1'b0; ic.start = 1'b0;
    checks++;
    if ({ic.x, ic.y, ic.z} !== 3'd6 || ic.busy !== 1'b1) begin
      errors++; $display("FAIL div1_start sel=%0d busy=%b want 6 1", {ic.x, ic.y, ic.z}, ic.busy);
    end
    cyc(1);
    checks++;
    if ({ic.x, ic.y, ic.z} !== 3'd7 || ic.wrap !== 1'b0) begin
      errors++; $display("FAIL div1_step1 sel=%0d wrap=%b want 7 0", {ic.x, ic.y, ic.z}, ic.wrap);
    end
    cyc(1);
    checks++;
    if ({ic.x, ic.y, ic.z} !== 3'd0 || ic.wrap !== 1'b1) begin
      errors++; $display("FAIL div1_wrap sel=%0d wrap=%b want 0 1", {ic.x, ic.y, ic.z}, ic.wrap);
    end
    ic.stop = 1'b1;
    cyc(1);
    ic.stop = 1'b0;
    checks++;
    if (ic.busy !== 1'b0 || ic.wrap !== 1'b0) begin
      errors++; $display("FAIL div1_stop busy=%b wrap=%b want 0 0", ic.busy, ic.wrap);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ia.start = 1'b0; ia.stop = 1'b0; ia.dir = 1'b0; ia.mode = 1'b0;
    ia.step_en = 1'b1; ia.load = 1'b0; ia.load_val = 3'd0;
    ib.start = 1'b0; ib.stop = 1'b0; ib.dir = 1'b0; ib.mode = 1'b0;
    ib.step_en = 1'b1; ib.load = 1'b0; ib.load_val = 3'd0;
    ic.start = 1'b0; ic.stop = 1'b0; ic.dir = 1'b0; ic.mode = 1'b0;
    ic.step_en = 1'b1; ic.load = 1'b0; ic.load_val = 3'd0;

    test_reset();
    test_oneshot_up();
    test_wrap_down();
    test_step_en();
    test_stop_tick();
    test_async_reset();
    test_div1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
